// File: rtl/spb_addr_dec_if.sv
// SPB bus bundle: one request/response channel per port, slices packed [i*W +: W].
// The master modport drives the request side, the slave modport drives the response side.
interface spb_addr_dec_if #(
    parameter int unsigned NUM_PORTS = 1
);
    logic [NUM_PORTS-1:0]    valid;
    logic [4*NUM_PORTS-1:0]  wstb;
    logic [32*NUM_PORTS-1:0] addr;
    logic [32*NUM_PORTS-1:0] wdata;
    logic [NUM_PORTS-1:0]    ready;
    logic [32*NUM_PORTS-1:0] rdata;
    logic [NUM_PORTS-1:0]    excpt;

    modport master (
        output valid, wstb, addr, wdata,
        input  ready, rdata, excpt
    );

    modport slave (
        input  valid, wstb, addr, wdata,
        output ready, rdata, excpt
    );
endinterface

// File: rtl/spb_addr_dec.sv
// SPB address decoder: one upstream master to NUM_PORTS slaves, selected by the top SEL_W address bits.
// Define SPB_ADDR_DEC_TIMEOUT_EN to add the downstream READY timeout (TIMEOUT cycles, then error).
module spb_addr_dec #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    spb_addr_dec_if.slave   s_spb,
    spb_addr_dec_if.master  m_spb,
    output logic [7:0]      err_cnt
);
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]    wstb;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    localparam bit CFG_OK = (NUM_PORTS >= 2) && (NUM_PORTS <= 8) &&
                            (SEL_W >= 1) && (SEL_W <= 31) &&
                            (NUM_PORTS <= (32'd1 << SEL_W)) &&
                            (TIMEOUT >= 2) && (TIMEOUT <= 65535);

    if (!CFG_OK) begin : g_bad_cfg
        $error("spb_addr_dec: NUM_PORTS, SEL_W or TIMEOUT out of range");
    end

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] valid_q, valid_d;
    logic [NUM_PORTS-1:0] req_oh;
    req_t                 req_q, req_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [SEL_W-1:0]     idx;
    logic                 up_valid;
    logic                 sel_ready;
    logic                 sel_excpt;
    logic [DW-1:0]        sel_rdata;
    logic                 rsp_busy;
    logic                 rsp_err;

`ifdef SPB_ADDR_DEC_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    assign up_valid = s_spb.valid[0];
    assign idx      = s_spb.addr[DW-1 -: SEL_W];

    // One-hot port decode; an address with no matching port is unmapped.
    always_comb begin
        req_oh = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            req_oh[i] = (idx == SEL_W'(i));
        end
    end

    // Response mux from the selected port; valid_q is one-hot only while BUSY.
    always_comb begin
        sel_ready = 1'b0;
        sel_excpt = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (valid_q[i]) begin
                sel_ready = sel_ready | m_spb.ready[i];
                sel_excpt = sel_excpt | m_spb.excpt[i];
                sel_rdata = sel_rdata | m_spb.rdata[DW*i +: DW];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        req_d     = req_q;
        err_cnt_d = err_cnt_q;
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (up_valid) begin
                    if (|req_oh) begin
                        state_d     = BUSY;
                        valid_d     = req_oh;
                        req_d.wstb  = s_spb.wstb;
                        req_d.addr  = s_spb.addr;
                        req_d.wdata = s_spb.wdata;
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (sel_ready) begin
                    state_d = IDLE;
                    valid_d = '0;
                end
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    valid_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ERR: begin
                state_d = IDLE;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            req_q     <= '0;
            err_cnt_q <= '0;
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            err_cnt_q <= err_cnt_d;
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Only the selected slice carries the payload; every other slice stays 0.
    always_comb begin
        m_spb.wstb  = '0;
        m_spb.addr  = '0;
        m_spb.wdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (valid_q[i]) begin
                m_spb.wstb[4*i +: 4]   = req_q.wstb;
                m_spb.addr[DW*i +: DW]  = req_q.addr;
                m_spb.wdata[DW*i +: DW] = req_q.wdata;
            end
        end
    end

    assign m_spb.valid = valid_q;
    assign err_cnt     = err_cnt_q;

    // Upstream response; an abandoned request (VALID dropped) gets no response.
    assign rsp_busy       = (state_q == BUSY) & sel_ready;
    assign rsp_err        = (state_q == ERR);
    assign s_spb.ready[0] = up_valid & (rsp_busy | rsp_err);
    assign s_spb.excpt[0] = up_valid & (rsp_err | (rsp_busy & sel_excpt));
    assign s_spb.rdata    = (up_valid & rsp_busy) ? sel_rdata : '0;

endmodule

// File: tb/tb_spb_addr_dec.sv
// Directed bench for spb_addr_dec (3 ports, SEL_W=2, TIMEOUT=16) with a per-cycle transaction model.
module tb_spb_addr_dec;
    localparam int unsigned NP = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned TO = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] err_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    spb_addr_dec_if #(.NUM_PORTS(1))  s_if ();
    spb_addr_dec_if #(.NUM_PORTS(NP)) m_if ();

    spb_addr_dec #(.NUM_PORTS(NP), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_spb  (s_if),
        .m_spb  (m_if),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which port is outstanding, how long it has waited, pending error.
    int          pend      = -1;
    int          waited    = 0;
    bit          err_now   = 1'b0;
    int          model_cnt = 0;
    logic [3:0]  p_wstb    = '0;
    logic [31:0] p_addr    = '0;
    logic [31:0] p_wdata   = '0;

    always @(negedge clk) begin : compare
        logic [NP-1:0]    e_valid;
        logic [4*NP-1:0]  e_wstb;
        logic [32*NP-1:0] e_addr;
        logic [32*NP-1:0] e_wdata;
        logic             done;
        logic             slv_excpt;
        logic [31:0]      slv_rdata;
        logic             up;
        int               region;

        if (!rst_n) begin
            pend = -1; waited = 0; err_now = 1'b0; model_cnt = 0;
        end
        e_valid = '0; e_wstb = '0; e_addr = '0; e_wdata = '0;
        done = 1'b0; slv_excpt = 1'b0; slv_rdata = '0;
        for (int i = 0; i < int'(NP); i++) begin
            if (i == pend) begin
                e_valid[i]          = 1'b1;
                e_wstb[4*i +: 4]    = p_wstb;
                e_addr[32*i +: 32]  = p_addr;
                e_wdata[32*i +: 32] = p_wdata;
                done                = m_if.ready[i];
                slv_excpt           = m_if.excpt[i];
                slv_rdata           = m_if.rdata[32*i +: 32];
            end
        end
        up = s_if.valid[0];
        chk("m_valid", m_if.valid, e_valid);
        chk("m_wstb",  m_if.wstb,  e_wstb);
        chk("m_addr",  m_if.addr,  e_addr);
        chk("m_wdata", m_if.wdata, e_wdata);
        chk("s_ready", s_if.ready, up && (done || err_now));
        chk("s_excpt", s_if.excpt, up && (err_now || (done && slv_excpt)));
        chk("s_rdata", s_if.rdata, (up && done) ? slv_rdata : 32'h0);
        chk("err_cnt", err_cnt, model_cnt[7:0]);

        if (rst_n) begin
            if (err_now) begin
                err_now = 1'b0;
                if (model_cnt < 255) model_cnt++;
            end else if (pend >= 0) begin
                if (done) pend = -1;
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
                else if (waited == int'(TO) - 1) begin
                    pend = -1; err_now = 1'b1;
                end
`endif
                else waited++;
            end else if (up) begin
                region = int'(s_if.addr[31:30]);
                if (region < int'(NP)) begin
                    pend = region; waited = 0;
                    p_wstb = s_if.wstb; p_addr = s_if.addr; p_wdata = s_if.wdata;
                end else begin
                    err_now = 1'b1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
        s_if.valid = 1'b1; s_if.addr = a; s_if.wstb = ws; s_if.wdata = wd;
    endtask

    task automatic idle_up();
        s_if.valid = 1'b0; s_if.addr = '0; s_if.wstb = '0; s_if.wdata = '0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        idle_up();
        m_if.ready = '0; m_if.rdata = '0; m_if.excpt = '0;
        #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("rst_errcnt", err_cnt, 8'd0);
        chk("rst_mvalid", m_if.valid, 3'b000);

        // Mapped read, slave ready on its first VALID cycle
        m_if.rdata = {32'h0, 32'hDEAD_BEEF, 32'h0};
        m_if.ready = 3'b010;
        req(32'h4000_0010, 4'h0, 32'h0);
        step(1);
        chk("rd_mvalid", m_if.valid, 3'b010);
        chk("rd_maddr1", m_if.addr[63:32], 32'h4000_0010);
        chk("rd_sready", s_if.ready, 1'b1);
        chk("rd_rdata",  s_if.rdata, 32'hDEAD_BEEF);
        chk("rd_excpt",  s_if.excpt, 1'b0);
        step(1);
        idle_up(); m_if.ready = '0; m_if.rdata = '0;
        step(2);

        // Mapped write, slave stalls three cycles
        req(32'h0000_0100, 4'b0011, 32'h1234_5678);
        step(1);
        chk("wr_mvalid", m_if.valid, 3'b001);
        chk("wr_wstb",   m_if.wstb,  12'h003);
        chk("wr_addr",   m_if.addr,  {64'h0, 32'h0000_0100});
        chk("wr_wdata",  m_if.wdata, {64'h0, 32'h1234_5678});
        chk("wr_stall",  s_if.ready, 1'b0);
        step(3);
        m_if.ready = 3'b001;
        #1;
        chk("wr_sready", s_if.ready, 1'b1);
        chk("wr_excpt",  s_if.excpt, 1'b0);
        step(1);
        idle_up(); m_if.ready = '0;
        step(2);

        // Unmapped access
        req(32'hC000_0000, 4'h0, 32'h0);
        step(1);
        chk("unm_mvalid", m_if.valid, 3'b000);
        chk("unm_sready", s_if.ready, 1'b1);
        chk("unm_excpt",  s_if.excpt, 1'b1);
        chk("unm_rdata",  s_if.rdata, 32'h0);
        step(1);
        idle_up();
        chk("unm_errcnt", err_cnt, 8'd1);
        step(2);

        // Port 2 never answers
        req(32'h8000_0000, 4'h0, 32'h0);
        step(1);
`ifdef SPB_ADDR_DEC_TIMEOUT_EN
        k = 0;
        while (m_if.valid[2] && k < 40) begin
            k++;
            step(1);
        end
        chk("to_vcycles", k, 16);
        chk("to_sready", s_if.ready, 1'b1);
        chk("to_excpt",  s_if.excpt, 1'b1);
        step(1);
        idle_up();
        m_if.ready = 3'b100;
        step(3);
        chk("to_late",   s_if.ready, 1'b0);
        chk("to_errcnt", err_cnt, 8'd2);
        m_if.ready = '0;
`else
        step(40);
        chk("nto_mvalid", m_if.valid, 3'b100);
        chk("nto_sready", s_if.ready, 1'b0);
        m_if.ready = 3'b100;
        #1;
        chk("nto_done", s_if.ready, 1'b1);
        step(1);
        idle_up(); m_if.ready = '0;
`endif
        step(2);

        // Upstream abandons the request; the late slave response is discarded
        req(32'h0000_0020, 4'h0, 32'h0);
        step(1);
        idle_up();
        step(1);
        m_if.ready = 3'b001;
        #1;
        chk("drop_sready", s_if.ready, 1'b0);
        chk("drop_mvalid", m_if.valid, 3'b001);
        step(1);
        m_if.ready = '0;
        chk("drop_idle", m_if.valid, 3'b000);
        step(2);

        // Back-to-back with VALID held, second response carries a slave exception
        m_if.ready = 3'b011;
        m_if.rdata = {32'h0, 32'h1111_1111, 32'h2222_2222};
        m_if.excpt = 3'b010;
        req(32'h0000_0010, 4'h0, 32'h0);
        step(1);
        chk("b2b_v1",  m_if.valid, 3'b001);
        chk("b2b_r1",  s_if.ready, 1'b1);
        chk("b2b_d1",  s_if.rdata, 32'h2222_2222);
        chk("b2b_e1",  s_if.excpt, 1'b0);
        step(1);
        chk("b2b_idle", m_if.valid, 3'b000);
        req(32'h4000_0020, 4'hF, 32'hA5A5_0000);
        step(1);
        chk("b2b_v2",  m_if.valid, 3'b010);
        chk("b2b_a2",  m_if.addr[63:32], 32'h4000_0020);
        chk("b2b_r2",  s_if.ready, 1'b1);
        chk("b2b_d2",  s_if.rdata, 32'h1111_1111);
        chk("b2b_e2",  s_if.excpt, 1'b1);
        step(1);
        idle_up(); m_if.ready = '0; m_if.excpt = '0; m_if.rdata = '0;
        step(2);

        // 300 unmapped accesses saturate the error counter
        req(32'hC000_0000, 4'h0, 32'h0);
        step(600);
        idle_up();
        step(2);
        chk("sat_errcnt", err_cnt, 8'd255);

        // Reset while port 1 is pending
        req(32'h4000_0000, 4'h0, 32'h0);
        step(1);
        chk("rb_mvalid", m_if.valid, 3'b010);
        #2 rst_n = 1'b0;
        idle_up();
        #1;
        chk("rst_mid_mvalid", m_if.valid, 3'b000);
        chk("rst_mid_sready", s_if.ready, 1'b0);
        chk("rst_mid_errcnt", err_cnt, 8'd0);
        step(2);
        rst_n = 1'b1;
        m_if.ready = 3'b010;
        m_if.rdata = {32'h0, 32'hCAFE_F00D, 32'h0};
        req(32'h4000_0004, 4'h0, 32'h0);
        step(1);
        chk("post_rst_sready", s_if.ready, 1'b1);
        chk("post_rst_rdata",  s_if.rdata, 32'hCAFE_F00D);
        step(1);
        idle_up(); m_if.ready = '0; m_if.rdata = '0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
